regfile_write_queue: RTL and testbench

Buffered writer for the 32×32 register file's single write port. Execute and load-return units push `(register, data)` results through a valid/ready handshake. The block queues them in order and drains at most one per cycle onto `reg_write`/`write_register`/`write_data`. It also gives the two read ports a forwarding view of writes that have not yet reached the register file. It sits between the writeback mux and the register file.

---
 rtl/regfile_write_queue.sv | 131 +++++++++++++
 tb/tb_regfile_write_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// Buffered writer for the register file's single write port: an in-order FIFO
// drained one entry per cycle, with a forwarding view of not-yet-committed writes.
module regfile_write_queue #(
   parameter int size  = 32,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [4:0]                in_reg,
   input  logic [size-1:0]           in_data,
   input  logic                      drain_en,
   output logic                      reg_write,
   output logic [4:0]                write_register,
   output logic [size-1:0]           write_data,
   input  logic [4:0]                read_reg_1,
   input  logic [4:0]                read_reg_2,
   output logic                      fwd_hit_1,
   output logic [size-1:0]           fwd_data_1,
   output logic                      fwd_hit_2,
   output logic [size-1:0]           fwd_data_2,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [4:0]      regMemQ  [DEPTH];
   logic [size-1:0] dataMemQ [DEPTH];

   logic [PW-1:0]   rdPtrQ, rdPtrD;
   logic [PW-1:0]   wrPtrQ, wrPtrD;
   logic [CW-1:0]   countQ, countD;
   logic            outValidQ, outValidD;
   logic [4:0]      outRegQ, outRegD;
   logic [size-1:0] outDataQ, outDataD;
   logic            push;
   logic            pop;
   logic [PW-1:0]   fwdIdx;

   assign in_ready = rst_n && (countQ < FULL);
   assign push     = in_valid && in_ready;
   assign pop      = drain_en && (countQ != '0);

   assign reg_write      = outValidQ;
   assign write_register = outRegQ;
   assign write_data     = outDataQ;
   assign count          = countQ;

   always_comb begin
      rdPtrD    = rdPtrQ;
      wrPtrD    = wrPtrQ;
      countD    = countQ;
      outValidD = 1'b0;
      outRegD   = outRegQ;
      outDataD  = outDataQ;
      if (push) begin
         wrPtrD = wrPtrQ + 1'b1;
      end
      if (pop) begin
         rdPtrD    = rdPtrQ + 1'b1;
         outValidD = 1'b1;
         outRegD   = regMemQ[rdPtrQ];
         outDataD  = dataMemQ[rdPtrQ];
      end
      case ({push, pop})
         2'b10:   countD = countQ + 1'b1;
         2'b01:   countD = countQ - 1'b1;
         default: countD = countQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdPtrQ    <= '0;
         wrPtrQ    <= '0;
         countQ    <= '0;
         outValidQ <= 1'b0;
         outRegQ   <= '0;
         outDataQ  <= '0;
      end else begin
         rdPtrQ    <= rdPtrD;
         wrPtrQ    <= wrPtrD;
         countQ    <= countD;
         outValidQ <= outValidD;
         outRegQ   <= outRegD;
         outDataQ  <= outDataD;
      end
   end

   // Payload storage needs no reset; occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (push) begin
         regMemQ[wrPtrQ]  <= in_reg;
         dataMemQ[wrPtrQ] <= in_data;
      end
   end

   // Scan oldest to youngest so later matches override: output stage first, then head to tail-1.
   always_comb begin
      fwd_hit_1  = 1'b0;
      fwd_data_1 = '0;
      fwd_hit_2  = 1'b0;
      fwd_data_2 = '0;
      fwdIdx     = rdPtrQ;
      if (outValidQ && (outRegQ == read_reg_1)) begin
         fwd_hit_1  = 1'b1;
         fwd_data_1 = outDataQ;
      end
      if (outValidQ && (outRegQ == read_reg_2)) begin
         fwd_hit_2  = 1'b1;
         fwd_data_2 = outDataQ;
      end
      for (int k = 0; k < DEPTH; k++) begin
         fwdIdx = rdPtrQ + PW'(k);
         if (CW'(k) < countQ) begin
            if (regMemQ[fwdIdx] == read_reg_1) begin
               fwd_hit_1  = 1'b1;
               fwd_data_1 = dataMemQ[fwdIdx];
            end
            if (regMemQ[fwdIdx] == read_reg_2) begin
               fwd_hit_2  = 1'b1;
               fwd_data_2 = dataMemQ[fwdIdx];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue: directed stimulus pushes expected
// writes; a negedge monitor pops and compares every reg_write pulse.
module tb_regfile_write_queue;

   localparam int SIZE  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [4:0]      r;
      logic [SIZE-1:0] d;
   } wr_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      in_reg;
   logic [SIZE-1:0] in_data;
   logic            drain_en;
   logic            reg_write;
   logic [4:0]      write_register;
   logic [SIZE-1:0] write_data;
   logic [4:0]      read_reg_1;
   logic [4:0]      read_reg_2;
   logic            fwd_hit_1;
   logic [SIZE-1:0] fwd_data_1;
   logic            fwd_hit_2;
   logic [SIZE-1:0] fwd_data_2;
   logic [CW-1:0]   count;

   wr_t expQ[$];
   wr_t monExp;
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   regfile_write_queue #(.size(SIZE), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_reg(in_reg),
      .in_data(in_data),
      .drain_en(drain_en),
      .reg_write(reg_write),
      .write_register(write_register),
      .write_data(write_data),
      .read_reg_1(read_reg_1),
      .read_reg_2(read_reg_2),
      .fwd_hit_1(fwd_hit_1),
      .fwd_data_1(fwd_data_1),
      .fwd_hit_2(fwd_hit_2),
      .fwd_data_2(fwd_data_2),
      .count(count)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle's inputs; record=1 means this offer will eventually be written.
   task automatic applyStimulus(input logic valid, input logic [4:0] r, input logic [SIZE-1:0] d,
                                input logic drain, input logic record);
      in_valid = valid;
      in_reg   = r;
      in_data  = d;
      drain_en = drain;
      if (record) begin
         expQ.push_back('{r: r, d: d});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every write strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reg_write === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: got r%0d=0x%0h, expected no write", write_register, write_data);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("mon_write_register", 64'(write_register), 64'(monExp.r));
            checkOutput("mon_write_data", 64'(write_data), 64'(monExp.d));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset held two edges while a write is being offered.
      rst_n      = 1'b0;
      read_reg_1 = 5'd31;
      read_reg_2 = 5'd31;
      applyStimulus(1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 1'b0);
      tick();
      checkOutput("rst1_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst1_count", 64'(count), 64'd0);
      tick();
      checkOutput("rst2_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst2_count", 64'(count), 64'd0);
      checkOutput("rst_reg_write", 64'(reg_write), 64'd0);
      checkOutput("rst_write_register", 64'(write_register), 64'd0);
      checkOutput("rst_write_data", 64'(write_data), 64'd0);
      checkOutput("rst_fwd_hit_1", 64'(fwd_hit_1), 64'd0);
      checkOutput("rst_fwd_data_1", 64'(fwd_data_1), 64'd0);
      checkOutput("rst_fwd_hit_2", 64'(fwd_hit_2), 64'd0);
      checkOutput("rst_fwd_data_2", 64'(fwd_data_2), 64'd0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 5'd0, '0, 1'b1, 1'b0);
      #1;
      checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("post_rst_count", 64'(count), 64'd0);

      // Single write latency and forwarding window.
      read_reg_1 = 5'd5;
      read_reg_2 = 5'd0;
      applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 5'd0, '0, 1'b1, 1'b0);
      #1;
      checkOutput("lat_n_count", 64'(count), 64'd1);
      checkOutput("lat_n_reg_write", 64'(reg_write), 64'd0);
      checkOutput("lat_n_fwd_hit_1", 64'(fwd_hit_1), 64'd1);
      checkOutput("lat_n_fwd_data_1", 64'(fwd_data_1), 64'hDEAD_BEEF);
      checkOutput("lat_n_fwd_hit_2", 64'(fwd_hit_2), 64'd0);
      tick();
      checkOutput("lat_n1_reg_write", 64'(reg_write), 64'd1);
      checkOutput("lat_n1_write_register", 64'(write_register), 64'd5);
      checkOutput("lat_n1_fwd_hit_1", 64'(fwd_hit_1), 64'd1);
      checkOutput("lat_n1_fwd_data_1", 64'(fwd_data_1), 64'hDEAD_BEEF);
      checkOutput("lat_n1_count", 64'(count), 64'd0);
      tick();
      checkOutput("lat_n2_reg_write", 64'(reg_write), 64'd0);
      checkOutput("lat_n2_fwd_hit_1", 64'(fwd_hit_1), 64'd0);
      checkOutput("lat_n2_fwd_data_1", 64'(fwd_data_1), 64'd0);
      checkOutput("lat_n2_hold_register", 64'(write_register), 64'd5);
      checkOutput("lat_n2_hold_data", 64'(write_data), 64'hDEAD_BEEF);

      // Fill with drain stalled, hold a fifth offer, then drain through the wrap.
      read_reg_1 = 5'd4;
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 5'(i), 32'(i * 17), 1'b0, 1'b1);
         tick();
      end
      applyStimulus(1'b1, 5'd5, 32'h55, 1'b0, 1'b1);
      #1;
      checkOutput("fill_count", 64'(count), 64'd4);
      checkOutput("fill_in_ready", 64'(in_ready), 64'd0);
      checkOutput("fill_reg_write", 64'(reg_write), 64'd0);
      checkOutput("fill_fwd_data_1", 64'(fwd_data_1), 64'h44);
      tick();
      checkOutput("held_count", 64'(count), 64'd4);
      checkOutput("held_in_ready", 64'(in_ready), 64'd0);
      applyStimulus(1'b1, 5'd5, 32'h55, 1'b1, 1'b0);
      tick();
      checkOutput("drainA_count", 64'(count), 64'd3);
      checkOutput("drainA_in_ready", 64'(in_ready), 64'd1);
      checkOutput("drainA_reg_write", 64'(reg_write), 64'd1);
      tick();
      applyStimulus(1'b0, 5'd0, '0, 1'b1, 1'b0);
      checkOutput("drainB_count", 64'(count), 64'd3);
      checkOutput("drainB_reg_write", 64'(reg_write), 64'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("drain_reg_write", 64'(reg_write), 64'd1);
         checkOutput("drain_count", 64'(count), 64'(2 - k));
      end
      tick();
      checkOutput("drain_done_reg_write", 64'(reg_write), 64'd0);

      // Forward priority: youngest match wins, output stage is oldest.
      applyStimulus(1'b1, 5'd7, 32'h1, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b1, 5'd7, 32'h2, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b1, 5'd3, 32'h9, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 5'd0, '0, 1'b0, 1'b0);
      read_reg_2 = 5'd7;
      read_reg_1 = 5'd3;
      #1;
      checkOutput("prio_fwd_hit_2", 64'(fwd_hit_2), 64'd1);
      checkOutput("prio_fwd_data_2", 64'(fwd_data_2), 64'h2);
      checkOutput("prio_fwd_hit_1", 64'(fwd_hit_1), 64'd1);
      checkOutput("prio_fwd_data_1", 64'(fwd_data_1), 64'h9);
      read_reg_1 = 5'd8;
      #1;
      checkOutput("prio_miss_hit_1", 64'(fwd_hit_1), 64'd0);
      checkOutput("prio_miss_data_1", 64'(fwd_data_1), 64'd0);
      applyStimulus(1'b0, 5'd0, '0, 1'b1, 1'b0);
      tick();
      checkOutput("prio_pop1_fwd_data_2", 64'(fwd_data_2), 64'h2);
      tick();
      checkOutput("prio_pop2_fwd_hit_2", 64'(fwd_hit_2), 64'd1);
      checkOutput("prio_pop2_fwd_data_2", 64'(fwd_data_2), 64'h2);
      tick();
      checkOutput("prio_pop3_fwd_hit_2", 64'(fwd_hit_2), 64'd0);
      checkOutput("prio_pop3_fwd_data_2", 64'(fwd_data_2), 64'd0);
      tick();
      checkOutput("prio_done_reg_write", 64'(reg_write), 64'd0);
      checkOutput("prio_done_count", 64'(count), 64'd0);

      // Stream ten writes (registers 0..9); stall drain on the last so two stay pending.
      read_reg_1 = 5'd9;
      read_reg_2 = 5'd8;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 5'(i), 32'(32'h100 + i), (i < 9), 1'b1);
         tick();
         checkOutput("stream_count", 64'(count), (i < 9) ? 64'd1 : 64'd2);
      end
      applyStimulus(1'b0, 5'd0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("pend_reg_write", 64'(reg_write), 64'd0);
      checkOutput("pend_fwd_data_1", 64'(fwd_data_1), 64'h109);
      checkOutput("pend_fwd_data_2", 64'(fwd_data_2), 64'h108);
      checkOutput("pend_sb_size", 64'(expQ.size()), 64'd2);
      rst_n = 1'b0;
      void'(expQ.pop_back());
      void'(expQ.pop_back());
      tick();
      checkOutput("mrst_count", 64'(count), 64'd0);
      checkOutput("mrst_reg_write", 64'(reg_write), 64'd0);
      checkOutput("mrst_fwd_hit_1", 64'(fwd_hit_1), 64'd0);
      checkOutput("mrst_fwd_data_1", 64'(fwd_data_1), 64'd0);
      checkOutput("mrst_in_ready", 64'(in_ready), 64'd0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b0, 5'd0, '0, 1'b1, 1'b0);
      #1;
      checkOutput("mrst_release_in_ready", 64'(in_ready), 64'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
      end
      checkOutput("idle_count", 64'(count), 64'd0);
      checkOutput("sb_drained", 64'(expQ.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
